// File: rtl/lockstep_pkg.sv
// Shared types for the lockstep checker: FSM states, mismatch vector bit
// positions and the per-core bus bundle compared every cycle.
package lockstep_pkg;

  typedef enum logic [1:0] {
    StCheck   = 2'd0,
    StSuspect = 2'd1,
    StError   = 2'd2
  } state_t;

  // Bit positions inside the mismatch vector.
  localparam int unsigned MV_IREQ  = 0;
  localparam int unsigned MV_IADDR = 1;
  localparam int unsigned MV_DREQ  = 2;
  localparam int unsigned MV_DCTRL = 3;
  localparam int unsigned MV_WDATA = 4;
  localparam int unsigned MV_W     = 5;

  typedef struct packed {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
  } core_bus_t;

  // Expand a 4-bit byte enable into a 32-bit bit mask.
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/lockstep_cmp.sv
// Registered field comparator between the two lockstepped core buses.
// Fields are only compared when the request that qualifies them is active.
module lockstep_cmp
  import lockstep_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            enable_i,
  input  core_bus_t       bus0_i,
  input  core_bus_t       bus1_i,
  output logic [MV_W-1:0] vec_o
);

  logic [MV_W-1:0] vec_d, vec_q;
  logic [31:0]     wmask;
  logic            ireq_any, dreq_any, wr_any;

  // Per-field divergence for this cycle; forced clean while checking is disabled.
  always_comb begin
    vec_d    = '0;
    ireq_any = bus0_i.ireq | bus1_i.ireq;
    dreq_any = bus0_i.dreq | bus1_i.dreq;
    wr_any   = (bus0_i.dreq & bus0_i.dwe) | (bus1_i.dreq & bus1_i.dwe);
    // Only bytes enabled by either core are meaningful write data.
    wmask    = be_to_mask(bus0_i.dbe | bus1_i.dbe);
    if (enable_i) begin
      vec_d[MV_IREQ]  = bus0_i.ireq != bus1_i.ireq;
      vec_d[MV_IADDR] = ireq_any && (bus0_i.iaddr != bus1_i.iaddr);
      vec_d[MV_DREQ]  = bus0_i.dreq != bus1_i.dreq;
      vec_d[MV_DCTRL] = dreq_any &&
                        ({bus0_i.dwe, bus0_i.dbe, bus0_i.daddr} !=
                         {bus1_i.dwe, bus1_i.dbe, bus1_i.daddr});
      vec_d[MV_WDATA] = wr_any && ((bus0_i.dwdata & wmask) != (bus1_i.dwdata & wmask));
    end
  end

  // Compare register: one cycle of latency from bus to mismatch vector.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vec_q <= '0;
    end else begin
      vec_q <= vec_d;
    end
  end

  assign vec_o = vec_q;

endmodule

// File: rtl/lockstep_checker.sv
// Lockstep checker for a dual zeroriscy SoC: compares both cores' bus requests,
// filters single-cycle transients and raises a sticky fault plus halt request.
// Optional first-mismatch log enabled by defining LOCKSTEP_CHECKER_LOG_EN.
module lockstep_checker
  import lockstep_pkg::*;
#(
  parameter int unsigned CONFIRM_CYCLES = 2,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic             instr_req_0_i,
  input  logic             instr_req_1_i,
  input  logic [31:0]      instr_addr_0_i,
  input  logic [31:0]      instr_addr_1_i,
  input  logic             data_req_0_i,
  input  logic             data_req_1_i,
  input  logic             data_we_0_i,
  input  logic             data_we_1_i,
  input  logic [3:0]       data_be_0_i,
  input  logic [3:0]       data_be_1_i,
  input  logic [31:0]      data_addr_0_i,
  input  logic [31:0]      data_addr_1_i,
  input  logic [31:0]      data_wdata_0_i,
  input  logic [31:0]      data_wdata_1_i,
  output logic             mismatch_o,
  output logic [MV_W-1:0]  mismatch_vec_o,
  output logic             error_o,
  output logic             halt_req_o,
  output logic [CNT_W-1:0] err_count_o
`ifdef LOCKSTEP_CHECKER_LOG_EN
  ,
  output logic [31:0]      first_iaddr_o,
  output logic [MV_W-1:0]  first_vec_o
`endif
);

  localparam int unsigned RunW = (CONFIRM_CYCLES < 2) ? 1 : $clog2(CONFIRM_CYCLES + 1);

  core_bus_t       bus0, bus1;
  logic [MV_W-1:0] vec;
  logic            mismatch;

  state_t          state_d, state_q;
  logic [RunW-1:0] run_d, run_q;
  logic [RunW-1:0] run_inc;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [CNT_W-1:0] cnt_sat;

  assign bus0 = '{ireq: instr_req_0_i, iaddr: instr_addr_0_i, dreq: data_req_0_i,
                  dwe: data_we_0_i, dbe: data_be_0_i, daddr: data_addr_0_i,
                  dwdata: data_wdata_0_i};
  assign bus1 = '{ireq: instr_req_1_i, iaddr: instr_addr_1_i, dreq: data_req_1_i,
                  dwe: data_we_1_i, dbe: data_be_1_i, daddr: data_addr_1_i,
                  dwdata: data_wdata_1_i};

  lockstep_cmp u_cmp (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .enable_i (enable_i),
    .bus0_i   (bus0),
    .bus1_i   (bus1),
    .vec_o    (vec)
  );

  assign mismatch = |vec;

  // Next-state for the transient filter FSM, run length and saturating counter.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    cnt_d   = cnt_q;
    run_inc = run_q + RunW'(1);
    cnt_sat = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    case (state_q)
      StCheck: begin
        if (enable_i && mismatch) begin
          run_d = RunW'(1);
          cnt_d = cnt_sat;
          state_d = (CONFIRM_CYCLES <= 1) ? StError : StSuspect;
        end
      end
      StSuspect: begin
        if (enable_i) begin
          if (mismatch) begin
            run_d = run_inc;
            if (run_inc >= RunW'(CONFIRM_CYCLES)) begin
              state_d = StError;
            end
          end else begin
            run_d   = '0;
            state_d = StCheck;
          end
        end
      end
      StError: begin
        // Acknowledge wins over any mismatch seen this cycle; it is re-evaluated next cycle.
        if (clear_i) begin
          run_d   = '0;
          state_d = StCheck;
        end
      end
      default: begin
        run_d   = '0;
        state_d = StCheck;
      end
    endcase
  end

  // FSM, run length and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StCheck;
      run_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mismatch_o     = mismatch;
  assign mismatch_vec_o = vec;
  assign error_o        = (state_q == StError);
  assign halt_req_o     = error_o;
  assign err_count_o    = cnt_q;

`ifdef LOCKSTEP_CHECKER_LOG_EN
  logic [31:0]     iaddr_dly_d, iaddr_dly_q;
  logic            logged_d, logged_q;
  logic [31:0]     first_iaddr_d, first_iaddr_q;
  logic [MV_W-1:0] first_vec_d, first_vec_q;

  // Capture the first mismatch since reset or acknowledge; address is delayed to match vec.
  always_comb begin
    iaddr_dly_d   = instr_addr_0_i;
    logged_d      = logged_q;
    first_iaddr_d = first_iaddr_q;
    first_vec_d   = first_vec_q;
    if ((state_q == StError) && clear_i) begin
      logged_d      = 1'b0;
      first_iaddr_d = '0;
      first_vec_d   = '0;
    end else if (mismatch && !logged_q) begin
      logged_d      = 1'b1;
      first_iaddr_d = iaddr_dly_q;
      first_vec_d   = vec;
    end
  end

  // Log registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      iaddr_dly_q   <= '0;
      logged_q      <= 1'b0;
      first_iaddr_q <= '0;
      first_vec_q   <= '0;
    end else begin
      iaddr_dly_q   <= iaddr_dly_d;
      logged_q      <= logged_d;
      first_iaddr_q <= first_iaddr_d;
      first_vec_q   <= first_vec_d;
    end
  end

  assign first_iaddr_o = first_iaddr_q;
  assign first_vec_o   = first_vec_q;
`endif

endmodule
